micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
- Microprogram sequencer for one processor core of the multicore matrix-multiply engine.
- Owns the micro-PC (upc), which addresses the control store.
- Each cycle it selects the next upc from one of four sources: increment, unconditional jump, conditional jump on the ALU Z flag, or dispatch to the address produced by mapping_block for the current IR.
- Also provides the start/done handshake to the top-level core scheduler, plus stall and illegal-microinstruction handling.

Parameters:
- UADDR_W, 16, width of upc, jmp_addr and map_addr (matches mapping_block map_addr).
- FETCH_ADDR, 0, microcode address of the instruction-fetch routine; upc value on reset and on start.
- CNT_W, 16, width of the dispatched-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from core scheduler to begin execution; sampled only in IDLE.
- map_addr  in  UADDR_W  dispatch target from mapping_block (combinational from IR).
- next_sel  in  3  next-address field of the current microinstruction (combinational control-store read at upc).
- jmp_addr  in  UADDR_W  branch-target field of the current microinstruction.
- z_flag  in  1  ALU zero flag.
- stall  in  1  memory/bus wait; holds the sequencer.
- upc  out  UADDR_W  micro-PC driving the control-store address.
- ctrl_valid  out  1  high when the microinstruction at upc may be executed this cycle (RUN and not stall).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on halt.
- illegal  out  1  sticky; set by an undefined next_sel, cleared by rst or an accepted start.
- instr_count  out  CNT_W  number of dispatches since the last accepted start.

Behaviour:
- Reset (rst=1 at clock edge, any state, including mid-RUN):
  - state=IDLE, upc=FETCH_ADDR.
  - busy=0, done=0, ctrl_valid=0, illegal=0, instr_count=0.
  - rst overrides start, stall and next_sel.
- States: IDLE, RUN, HALT. All outputs are registered except ctrl_valid = (state==RUN) & ~stall.
- IDLE:
  - start=1 -> RUN next cycle, with upc=FETCH_ADDR, illegal=0, instr_count=0.
  - start=0 -> stay in IDLE.
- RUN with stall=1: upc, state and instr_count hold; next_sel is ignored. stall has priority over every next_sel value.
- RUN with stall=0, next_sel decoded on the clock edge:
  - 0 INC: upc <= upc+1, modulo 2^UADDR_W (0xFFFF wraps to 0x0000, no flag).
  - 1 JMP: upc <= jmp_addr.
  - 2 JZ: upc <= z_flag ? jmp_addr : upc+1.
  - 3 JNZ: upc <= z_flag ? upc+1 : jmp_addr.
  - 4 DISPATCH: upc <= map_addr; instr_count <= instr_count+1, wrapping at 2^CNT_W.
  - 5 HALT: go to HALT; upc holds.
  - 6, 7 undefined: treated as HALT and illegal <= 1.
- Latency: one cycle from a next_sel decision to the new upc. Start to first executed microinstruction is 1 cycle (IDLE edge -> RUN with upc=FETCH_ADDR).
- HALT:
  - lasts exactly one cycle with done=1 and busy=0.
  - then IDLE unconditionally; upc is reloaded to FETCH_ADDR on the HALT->IDLE edge.
  - start asserted during HALT is ignored.
- start while busy=1 is ignored; it has no effect on upc or instr_count.
- z_flag is sampled only when next_sel is 2 or 3 and stall=0.
- illegal stays set through HALT and IDLE until the next accepted start or rst.

Test Plan:
- Reset then start: rst=1 for 2 cycles, start pulse -> next cycle busy=1, upc=0, ctrl_valid=1, illegal=0, instr_count=0; with next_sel=0 for 3 cycles -> upc 1, 2, 3.
- Dispatch sweep: for IR opcodes 0..28 feeding mapping_block, hold next_sel=4 -> after each edge upc==map_addr of that IR; after 29 dispatches instr_count==29.
- Conditional branches: upc=0x0010, jmp_addr=0x0040:
  - next_sel=2, z=1 -> 0x0040.
  - next_sel=2, z=0 -> 0x0011.
  - next_sel=3, z=1 -> 0x0011.
  - next_sel=3, z=0 -> 0x0040.
- Stall and wrap: JMP to 0xFFFF, then stall=1 for 4 cycles with next_sel=1 -> upc stays 0xFFFF and ctrl_valid=0; release stall with next_sel=0 -> upc=0x0000.
- Halt, illegal and restart:
  - next_sel=5 -> done=1 for exactly one cycle, busy=0, then IDLE with upc=0.
  - start pulses during HALT and during RUN -> ignored.
  - next_sel=7 in RUN -> done pulse, illegal=1 held in IDLE; a new start clears illegal.
- Reset mid-run: after 5 dispatches (instr_count=5, upc arbitrary), assert rst for one cycle -> upc=0, instr_count=0, state IDLE, no done pulse.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: picks the next micro-PC (inc/jump/cond-jump/dispatch) and runs the start/done handshake.
// Latency: one cycle from a next_sel decision to the new upc; start to first executed microinstruction is 1 cycle.
// Backpressure: stall freezes upc, state and instr_count; ctrl_valid is the only combinational output.
module micro_sequencer #(
  parameter int UADDR_W    = 16,
  parameter int FETCH_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [UADDR_W-1:0] map_addr,
  input  logic [2:0]         next_sel,
  input  logic [UADDR_W-1:0] jmp_addr,
  input  logic               z_flag,
  input  logic               stall,
  output logic [UADDR_W-1:0] upc,
  output logic               ctrl_valid,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [UADDR_W-1:0] FETCH = UADDR_W'(FETCH_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [UADDR_W-1:0] upc_inc;

  assign upc_inc = upc_q + UADDR_W'(1);

  // Next-state, next-upc and bookkeeping decode; everything holds by default.
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          upc_d     = FETCH;
          illegal_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_RUN: begin
        // A stalled cycle ignores next_sel entirely, including halts.
        if (!stall) begin
          unique case (next_sel)
            3'd0: upc_d = upc_inc;
            3'd1: upc_d = jmp_addr;
            3'd2: upc_d = z_flag ? jmp_addr : upc_inc;
            3'd3: upc_d = z_flag ? upc_inc : jmp_addr;
            3'd4: begin
              upc_d = map_addr;
              cnt_d = cnt_q + CNT_W'(1);
            end
            3'd5: state_d = S_HALT;
            default: begin
              // Undefined selector: stop the core and leave a sticky marker.
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_HALT: begin
        // Single-cycle done window, then park on the fetch routine.
        state_d = S_IDLE;
        upc_d   = FETCH;
      end
      default: begin
        state_d = S_IDLE;
        upc_d   = FETCH;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_HALT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      upc_q     <= FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign upc         = upc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;
  assign ctrl_valid  = (state_q == S_RUN) & ~stall;

endmodule
